seq_divider: RTL
================

Name: seq_divider

Overview:
- Multi-cycle signed integer divider for the processor's execute stage.
- Performs the inverse of the multiply path: one restoring subtract-and-shift step per clock, following the add_sub carry/compare convention.
- Accepts a one-cycle start pulse and returns quotient, remainder, ready and exception flags.
- Sits beside the ALU inside the mult/div unit and frees the ALU while a divide is in progress.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits (two's complement).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- ctrl_reset_n  input  1  asynchronous, active-low reset.
- ctrl_DIV  input  1  start pulse; operands are sampled on the edge where this is 1.
- data_operandA  input  WIDTH  dividend.
- data_operandB  input  WIDTH  divisor.
- data_result  output  WIDTH  quotient.
- data_remainder  output  WIDTH  remainder.
- data_resultRDY  output  1  one-cycle completion strobe.
- data_exception  output  1  error flag, valid while data_resultRDY=1 and held afterwards.
- busy  output  1  high while a divide is in flight.

Behaviour:
- Reset (ctrl_reset_n=0, asynchronous):
  - state=IDLE.
  - data_result, data_remainder, data_resultRDY, data_exception, busy and all internal registers = 0.
  - A reset mid-operation aborts the divide with no RDY strobe.
- State IDLE:
  - ctrl_DIV=1 on edge E0 latches A and B.
  - Stores |A| and |B| as unsigned WIDTH-bit magnitudes.
  - Stores quotient sign = A[msb]^B[msb] and remainder sign = A[msb].
  - Clears the partial remainder; count=0; busy=1.
  - Next state: CHECK.
- State CHECK (one cycle):
  - If B==0: data_result=0, data_remainder=A, data_exception=1, data_resultRDY=1, busy=0, go to IDLE. RDY is therefore high after edge E1.
  - Otherwise go to CALC.
- State CALC (WIDTH cycles):
  - Each cycle: shift {rem,quo} left by 1, bringing in the next dividend bit.
  - Compute trial = rem - |B| in WIDTH+1 bits, using inverted-B plus carry-in 1 as in add_sub.
  - If trial is non-negative: rem=trial and quo bit=1; else quo bit=0.
  - count increments; after count==WIDTH-1, go to FIX.
- State FIX (one cycle):
  - Negate quo if the quotient sign is set; negate rem if the remainder sign is set.
  - Drive data_result and data_remainder, pulse data_resultRDY=1, busy=0, go to IDLE.
  - Total latency: RDY high in the cycle after edge E(WIDTH+2), i.e. E34 for WIDTH=32.
- Semantics:
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - A = B*Q + R always holds, except in the overflow case below.
- Overflow: A=-2^(WIDTH-1) and B=-1 gives data_result=0x80000000, data_remainder=0, data_exception=1, normal latency.
- data_exception clears to 0 on the next accepted start.
- Outputs data_result, data_remainder and data_exception hold their values until the next completion or reset.
- data_resultRDY is registered and high for exactly one cycle per completed divide, never otherwise.
- ctrl_DIV=1 while busy (CHECK/CALC/FIX):
  - Aborts the current divide with no RDY.
  - Relatches new operands and restarts from CHECK on that same edge.
  - Start has priority over FIX completion.
- ctrl_DIV held high for multiple cycles restarts on every edge, so the controller must pulse it.

Test Plan:
- 100 / 7, single pulse -> RDY exactly one cycle at E34; result=14, remainder=2, exception=0; busy high from E1 through E33.
- -100 / 7 and 100 / -7 -> results -14/-2 and -14/2 respectively; -7 / -100 -> result 0, remainder -7.
- Divide by zero: 0x1234 / 0 -> RDY after E1; result=0, remainder=0x1234, exception=1; the next divide 9/3 clears exception and returns 3.
- Overflow: 0x80000000 / 0xFFFFFFFF -> result 0x80000000, remainder 0, exception=1 at E34; also 0x80000000 / 1 -> 0x80000000, exception=0.
- Restart: start 1000/3, reissue ctrl_DIV at E10 with 50/5 -> no RDY for the first divide; RDY at E10+34 with result=10.
- Reset: assert ctrl_reset_n=0 asynchronously at E20 of a divide -> all outputs 0 immediately, no RDY; a fresh 7/7 after release -> result 1 at E34.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed integer divider (restoring, one bit per clock).
// Operands are sampled on a start pulse; quotient truncates toward zero and the
// remainder carries the dividend's sign. Divide-by-zero and the single overflow
// case (most-negative / -1) raise data_exception.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        CALC  = 2'd2,
        FIX   = 2'd3
    } state_t;

    // Two's complement negation of an unsigned bit pattern.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Unsigned magnitude of a two's complement value; the most-negative value
    // maps to 2^(WIDTH-1), which is still representable unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? negate(v) : v;
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  rem_q, rem_d;         // partial remainder
    logic [WIDTH-1:0]  quo_q, quo_d;         // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]  bmag_q, bmag_d;
    logic [WIDTH-1:0]  a_q, a_d;             // original dividend for divide-by-zero
    logic              qsign_q, qsign_d;
    logic              rsign_q, rsign_d;
    logic              ovf_q, ovf_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [WIDTH-1:0]  remainder_q, remainder_d;
    logic              rdy_q, rdy_d;
    logic              exc_q, exc_d;
    logic              busy_q, busy_d;

    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    trial;

    // Next-state and datapath logic; a start pulse overrides every state.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        bmag_d      = bmag_q;
        a_d         = a_q;
        qsign_d     = qsign_q;
        rsign_d     = rsign_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        rdy_d       = 1'b0;
        exc_d       = exc_q;
        busy_d      = busy_q;

        // Bring the next dividend bit into the remainder, then subtract the
        // divisor via inverted-B plus carry-in; the top bit of trial is the sign.
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted + {1'b1, ~bmag_q} + (WIDTH+1)'(1);

        case (state_q)
            IDLE: begin
            end
            CHECK: begin
                if (bmag_q == '0) begin
                    result_d    = '0;
                    remainder_d = a_q;
                    exc_d       = 1'b1;
                    rdy_d       = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                // The partial remainder stays below |B| <= 2^(WIDTH-1), so
                // shifted never needs its top bit when the trial is restored.
                if (trial[WIDTH]) begin
                    rem_d = shifted[WIDTH-1:0];
                end else begin
                    rem_d = trial[WIDTH-1:0];
                end
                quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d    = qsign_q ? negate(quo_q) : quo_q;
                remainder_d = rsign_q ? negate(rem_q) : rem_q;
                exc_d       = ovf_q;
                rdy_d       = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A start aborts anything in flight, including a completing FIX, so
        // the visible results are left untouched and no strobe is produced.
        if (ctrl_DIV) begin
            a_d         = data_operandA;
            quo_d       = magnitude(data_operandA);
            bmag_d      = magnitude(data_operandB);
            qsign_d     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            rsign_d     = data_operandA[WIDTH-1];
            ovf_d       = (data_operandA == MOST_NEG) && (data_operandB == '1);
            rem_d       = '0;
            count_d     = '0;
            result_d    = result_q;
            remainder_d = remainder_q;
            exc_d       = 1'b0;
            rdy_d       = 1'b0;
            busy_d      = 1'b1;
            state_d     = CHECK;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            bmag_q      <= '0;
            a_q         <= '0;
            qsign_q     <= 1'b0;
            rsign_q     <= 1'b0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            rdy_q       <= 1'b0;
            exc_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            bmag_q      <= bmag_d;
            a_q         <= a_d;
            qsign_q     <= qsign_d;
            rsign_q     <= rsign_d;
            ovf_q       <= ovf_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            rdy_q       <= rdy_d;
            exc_q       <= exc_d;
            busy_q      <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_resultRDY = rdy_q;
    assign data_exception = exc_q;
    assign busy           = busy_q;

endmodule
